trap_controller: RTL
====================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter CSR_ADDR_W, default 12, CSR address width.
REQ-002 SHALL have ports clk input 1, system clock; rst input 1, reset, synchronous, active-high.
REQ-003 SHALL have exc_valid input 1, synchronous exception request; exc_cause input 5, exception code; exc_pc input 32, faulting PC.
REQ-004 SHALL have mret_req input 1, MRET retiring; cur_pc input 32, PC of next unexecuted instruction, used as mepc on interrupts.
REQ-005 SHALL have irq input 3, level interrupts {meip,mtip,msip}; mie_bits input 3, enables {MEIE,MTIE,MSIE}; mstatus_mie input 1, global enable.
REQ-006 SHALL have csr_addr output CSR_ADDR_W; csr_re output 1; csr_we output 1; csr_op output 3; csr_wdata output 32; csr_rdata input 32, combinational read data from the CSR unit.
REQ-007 SHALL have stall output 1, pipeline hold; redirect_valid output 1, one-cycle fetch redirect strobe; redirect_pc output 32, target.

Function
REQ-008 SHALL implement FSM states IDLE, T_EPC, T_CAUSE, T_STATUS, T_TVEC, M_STATUS, M_EPC, REDIRECT.
REQ-009 SHALL, in IDLE, select by priority: exc_valid > mret_req > interrupt; lower-priority requests that cycle are dropped.
REQ-010 SHALL take an interrupt only when mstatus_mie=1 and (irq & mie_bits)!=0, priority MEI (code 11) > MSI (3) > MTI (7).
REQ-011 SHALL, on trap acceptance, latch pc (exc_pc or cur_pc), cause {interrupt bit, 26'b0, code}, and go to T_EPC.
REQ-012 SHALL, in T_EPC, write mepc (0x341) = latched pc with {pc[31:2],2'b00}; go to T_CAUSE.
REQ-013 SHALL, in T_CAUSE, write mcause (0x342) = latched cause; go to T_STATUS.
REQ-014 SHALL, in T_STATUS, read mstatus (0x300) and same cycle write it with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11, other bits unchanged; go to T_TVEC.
REQ-015 SHALL, in T_TVEC, read mtvec (0x305): base={rdata[31:2],2'b00}; target=base+4*code when rdata[1:0]=2'b01 and interrupt, else base; register target; go to REDIRECT.
REQ-016 SHALL, on MRET acceptance, go to M_STATUS: read/write mstatus with MIE=MPIE, MPIE=1, MPP=2'b00; go to M_EPC.
REQ-017 SHALL, in M_EPC, read mepc and register {rdata[31:2],2'b00} as target; go to REDIRECT.
REQ-018 SHALL, in REDIRECT, assert redirect_valid=1 with redirect_pc=target for exactly one cycle, then return to IDLE.
REQ-019 SHALL drive every CSR write with csr_we=1, csr_op=3'b001 (full write); csr_re=1 only in read states; csr_we/csr_re=0, csr_addr=0, csr_wdata=0 otherwise.
REQ-020 SHALL assert stall=1 whenever state!=IDLE; requests arriving while stall=1 are ignored.
REQ-021 SHALL have latency: trap acceptance edge to redirect_valid = 5 cycles; MRET = 3 cycles.
REQ-022 SHALL never issue csr_we in IDLE, so pipeline CSR-instruction writes see no conflict.

Reset
REQ-023 SHALL, on rst=1 at clk edge, enter IDLE and clear latched pc, cause, target to 0, including mid-sequence; CSR writes already issued are not undone.
REQ-024 SHALL drive all outputs 0 while in reset and in IDLE.

Structure
REQ-025 SHALL take CSR addresses, csr_op encodings, cause codes and mstatus bit positions from the shared common library header; state encoding is local.
REQ-026 SHALL place interrupt gating/priority in one combinational sub-module, trap_cause_sel (inputs irq, mie_bits, mstatus_mie; outputs take, code).

Verification
REQ-027 exc_valid=1, exc_cause=11, exc_pc=0x0000_0104, mtvec=0x0000_0200 -> mepc=0x104, mcause=11, mstatus MIE 1->0, MPIE=1, MPP=3; redirect_pc=0x200 five cycles later.
REQ-028 irq=3'b100, mie_bits=3'b100, mstatus_mie=1, mtvec=0x0000_0201, cur_pc=0x80 -> mcause=0x8000_000B, mepc=0x80, redirect_pc=0x22C.
REQ-029 irq=3'b111, all enabled, mstatus_mie=0 -> no sequence, stall=0; set mstatus_mie=1 -> code 11 taken first.
REQ-030 mstatus=0x0000_0080, mepc=0x0000_0306, mret_req=1 -> mstatus=0x0000_0088, redirect_pc=0x304 three cycles later.
REQ-031 exc_valid and mret_req and enabled irq in same cycle -> exception sequence only; mret_req during stall ignored.
REQ-032 rst asserted in T_STATUS -> IDLE next cycle, stall=0, redirect_valid never pulses.

Source files
------------

// File: rtl/trap_controller_pkg.sv
// Shared CSR addresses, csr_op encodings, cause codes and mstatus bit positions
// used by the machine-mode trap sequencer.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] CSR_OP_NONE  = 3'b000;
  localparam logic [2:0] CSR_OP_WRITE = 3'b001;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/trap_controller_cause_sel.sv
// Interrupt gating and fixed priority selection: MEI > MSI > MTI.
module trap_cause_sel
  import trap_controller_pkg::*;
(
  input  logic [2:0] irq,
  input  logic [2:0] mie_bits,
  input  logic       mstatus_mie,
  output logic       take,
  output logic [4:0] code
);

  logic [2:0] w_pending;

  // Bit order is {external, timer, software} for both irq and mie_bits.
  assign w_pending = irq & mie_bits;
  assign take      = mstatus_mie & (|w_pending);

  always_comb begin
    code = 5'd0;
    if (w_pending[2]) begin
      code = CAUSE_MEI;
    end else if (w_pending[0]) begin
      code = CAUSE_MSI;
    end else if (w_pending[1]) begin
      code = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Multi-cycle machine-mode trap entry / MRET sequencer driving a single CSR port
// and a one-cycle fetch redirect.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_cause,
  input  logic [31:0]           exc_pc,
  input  logic                  mret_req,
  input  logic [31:0]           cur_pc,
  input  logic [2:0]            irq,
  input  logic [2:0]            mie_bits,
  input  logic                  mstatus_mie,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_re,
  output logic                  csr_we,
  output logic [2:0]            csr_op,
  output logic [31:0]           csr_wdata,
  input  logic [31:0]           csr_rdata,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STATUS, T_TVEC, M_STATUS, M_EPC, REDIRECT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_target;

  logic        w_irq_take;
  logic [4:0]  w_irq_code;
  logic [31:0] w_mstatus_trap;
  logic [31:0] w_mstatus_mret;
  logic [31:0] w_tvec_base;
  logic [31:0] w_tvec_target;

  trap_cause_sel u_cause_sel (
    .irq         (irq),
    .mie_bits    (mie_bits),
    .mstatus_mie (mstatus_mie),
    .take        (w_irq_take),
    .code        (w_irq_code)
  );

  always_comb begin
    w_mstatus_trap                                = csr_rdata;
    w_mstatus_trap[MSTATUS_MPIE]                  = csr_rdata[MSTATUS_MIE];
    w_mstatus_trap[MSTATUS_MIE]                   = 1'b0;
    w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    w_mstatus_mret                                = csr_rdata;
    w_mstatus_mret[MSTATUS_MIE]                   = csr_rdata[MSTATUS_MPIE];
    w_mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
    w_mstatus_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  // Vectored mode only applies to interrupts; exceptions always use the base.
  assign w_tvec_base   = word_align(csr_rdata);
  assign w_tvec_target = (csr_rdata[1:0] == 2'b01 && r_cause[31])
                         ? w_tvec_base + {25'd0, r_cause[4:0], 2'b00}
                         : w_tvec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs are forced low while rst is high, even mid-sequence.
  always_comb begin
    w_state_next   = r_state;
    csr_addr       = '0;
    csr_re         = 1'b0;
    csr_we         = 1'b0;
    csr_op         = CSR_OP_NONE;
    csr_wdata      = 32'd0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    if (!rst) begin
      stall = (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (exc_valid) begin
            w_state_next = T_EPC;
          end else if (mret_req) begin
            w_state_next = M_STATUS;
          end else if (w_irq_take) begin
            w_state_next = T_EPC;
          end
        end
        T_EPC: begin
          csr_addr     = CSR_ADDR_W'(CSR_MEPC);
          csr_we       = 1'b1;
          csr_op       = CSR_OP_WRITE;
          csr_wdata    = word_align(r_pc);
          w_state_next = T_CAUSE;
        end
        T_CAUSE: begin
          csr_addr     = CSR_ADDR_W'(CSR_MCAUSE);
          csr_we       = 1'b1;
          csr_op       = CSR_OP_WRITE;
          csr_wdata    = r_cause;
          w_state_next = T_STATUS;
        end
        T_STATUS: begin
          csr_addr     = CSR_ADDR_W'(CSR_MSTATUS);
          csr_re       = 1'b1;
          csr_we       = 1'b1;
          csr_op       = CSR_OP_WRITE;
          csr_wdata    = w_mstatus_trap;
          w_state_next = T_TVEC;
        end
        T_TVEC: begin
          csr_addr     = CSR_ADDR_W'(CSR_MTVEC);
          csr_re       = 1'b1;
          w_state_next = REDIRECT;
        end
        M_STATUS: begin
          csr_addr     = CSR_ADDR_W'(CSR_MSTATUS);
          csr_re       = 1'b1;
          csr_we       = 1'b1;
          csr_op       = CSR_OP_WRITE;
          csr_wdata    = w_mstatus_mret;
          w_state_next = M_EPC;
        end
        M_EPC: begin
          csr_addr     = CSR_ADDR_W'(CSR_MEPC);
          csr_re       = 1'b1;
          w_state_next = REDIRECT;
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          redirect_pc    = r_target;
          w_state_next   = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= 32'd0;
      r_cause  <= 32'd0;
      r_target <= 32'd0;
    end else begin
      if (r_state == IDLE) begin
        if (exc_valid) begin
          r_pc    <= exc_pc;
          r_cause <= {1'b0, 26'd0, exc_cause};
        end else if (!mret_req && w_irq_take) begin
          r_pc    <= cur_pc;
          r_cause <= {1'b1, 26'd0, w_irq_code};
        end
      end
      if (r_state == T_TVEC) begin
        r_target <= w_tvec_target;
      end
      if (r_state == M_EPC) begin
        r_target <= word_align(csr_rdata);
      end
    end
  end

endmodule
